mult_pipe_sched: RTL and testbench
==================================

Name: mult_pipe_sched

Overview:
- Issue scheduler for the 64-bit floating-point multiply datapath between the 512-to-64 read buffer and the 64-to-512 write buffer.
- Pops read-buffer words into the fixed-latency multiplier pipeline only when write-buffer space is guaranteed, using a credit counter.
- Tracks in-flight words and pads a trailing partial cache line with zero words so the write side always receives whole 512-bit lines.
- Reports busy, done and the output line count to the AFU control logic.

Parameters:
- PIPE_LAT, 4, multiplier pipeline latency in cycles, from issue to result valid.
- OUT_DEPTH, 16, write-buffer capacity in 64-bit words; this is the initial credit count.
- WORDS_PER_LINE, 8, 64-bit words per 512-bit line.
- LEN_W, 64, width of the word-count input.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start pulse
- num_words  in  LEN_W  number of 64-bit words to process; sampled on start
- in_empty  in  1  read buffer empty
- in_rd_en  out  1  pop one word from the read buffer (combinational)
- out_wr_en  out  1  push one multiplier result into the write buffer
- out_pad  out  1  aligned with out_wr_en; write-side mux selects 64'h0 instead of the multiplier result
- out_rd_en  in  1  write buffer popped one 512-bit line; returns WORDS_PER_LINE credits
- total_lines  out  LEN_W  ceil(num_words/WORDS_PER_LINE), registered on start
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- err_zero_len  out  1  sticky flag: the last start had num_words==0; cleared by the next start

Behaviour:
- Reset values: in_rd_en=0, out_wr_en=0, out_pad=0, busy=0, done=0, err_zero_len=0, total_lines=0, credits=OUT_DEPTH, delay line cleared, state=IDLE.
- Reset asserted mid-job aborts immediately. Words already in the multiplier are dropped: out_wr_en is forced to 0 while reset is high and the delay line is cleared.
- States: IDLE, RUN, PAD, DRAIN, DONE.
- IDLE, on start:
  - latch num_words;
  - set total_lines;
  - clear issued_cnt;
  - go to RUN, or to DONE with err_zero_len=1 if num_words==0.
- start while busy is ignored.
- RUN:
  - issue = !in_empty && credits!=0 && issued_cnt<num_words;
  - in_rd_en = issue;
  - issued_cnt increments on each issue.
- Leaving RUN: the cycle issued_cnt reaches num_words, go to PAD if num_words mod WORDS_PER_LINE != 0, else to DRAIN.
- PAD:
  - issue (WORDS_PER_LINE - rem) pad slots, one per cycle while credits!=0;
  - in_rd_en stays 0; the slot enters the delay line with pad=1;
  - go to DRAIN after the last pad slot.
- DRAIN: wait until the delay line holds no valid entry, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Delay line:
  - {valid,pad} shifted PIPE_LAT stages;
  - out_wr_en = valid at stage PIPE_LAT, i.e. exactly PIPE_LAT cycles after in_rd_en or the pad slot;
  - out_pad = pad at stage PIPE_LAT.
- Credits:
  - next = credits - issue_or_pad + (out_rd_en ? WORDS_PER_LINE : 0);
  - simultaneous consume and return is applied in the same cycle;
  - width is $clog2(OUT_DEPTH+1);
  - credits>OUT_DEPTH is an assertion failure;
  - out_rd_en in IDLE still returns credits.
- Throughput: 1 word/cycle when not starved and credits are available.
- Invariant: total out_wr_en count = total_lines*WORDS_PER_LINE.

Decomposition:
- Package mult_pipe_pkg: t_sched_state enum, WORDS_PER_LINE, default PIPE_LAT, and a credit-width function.
- One sub-module, valid_delay_line: parameterised PIPE_LAT-deep shift register of {valid,pad} with synchronous clear and an any_valid output.

Test Plan:
- num_words=16, in_empty=0, out_rd_en pulsed as lines fill:
  - in_rd_en high for 16 consecutive cycles;
  - out_wr_en exactly 4 cycles later each;
  - out_pad=0;
  - total_lines=2;
  - done pulses the cycle after the final out_wr_en.
- num_words=5:
  - 5 in_rd_en, 3 pad slots;
  - 8 out_wr_en, the last 3 with out_pad=1;
  - total_lines=1.
- num_words=40, no out_rd_en:
  - issue stops after 16 words, busy stays 1;
  - one out_rd_en pulse lets exactly 8 more issue;
  - the job completes once lines keep draining.
- num_words=8, in_empty toggling 1/0 every cycle: in_rd_en never asserts while in_empty=1; 8 writes total; done asserted.
- num_words=0: err_zero_len=1, done pulses within 2 cycles, in_rd_en and out_wr_en never assert; the next valid start clears err_zero_len.
- reset mid-run after 6 issues:
  - all outputs read reset values the next cycle;
  - no out_wr_en emerges afterward;
  - credits restored to 16;
  - a new 8-word job completes normally.
- start pulsed while busy: ignored; the running job's counts are unchanged.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared state type, line geometry and credit sizing for the multiply issue scheduler
package mult_pipe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAD,
    S_DRAIN,
    S_DONE
  } t_sched_state;

  localparam int WORDS_PER_LINE   = 8;
  localparam int DEFAULT_PIPE_LAT = 4;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - PIPE_LAT-deep {valid,pad} shift register shadowing the multiplier pipeline
module valid_delay_line #(
  parameter int PIPE_LAT = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic in_valid,
  input  logic in_pad,
  output logic out_valid,
  output logic out_pad,
  output logic any_valid
);

  logic [PIPE_LAT-1:0] vld_q, pad_q, vld_d, pad_d;

  always_comb begin
    vld_d = PIPE_LAT'({vld_q, in_valid});
    pad_d = PIPE_LAT'({pad_q, in_pad});
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      vld_q <= '0;
      pad_q <= '0;
    end else begin
      vld_q <= vld_d;
      pad_q <= pad_d;
    end
  end

  assign out_valid = vld_q[PIPE_LAT-1];
  assign out_pad   = pad_q[PIPE_LAT-1];
  // Entries still in flight after this cycle; the word leaving now is not counted.
  assign any_valid = |vld_d;

endmodule

// File: rtl/mult_pipe_sched.sv
// rtl/mult_pipe_sched.sv - credit-based issue scheduler feeding the fp64 multiplier, with line padding
module mult_pipe_sched import mult_pipe_pkg::*; #(
  parameter int PIPE_LAT       = mult_pipe_pkg::DEFAULT_PIPE_LAT,
  parameter int OUT_DEPTH      = 16,
  parameter int WORDS_PER_LINE = mult_pipe_pkg::WORDS_PER_LINE,
  parameter int LEN_W          = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] num_words,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic             out_wr_en,
  output logic             out_pad,
  input  logic             out_rd_en,
  output logic [LEN_W-1:0] total_lines,
  output logic             busy,
  output logic             done,
  output logic             err_zero_len
);

  localparam int CW = credit_width(OUT_DEPTH);
  localparam int PW = $clog2(WORDS_PER_LINE + 1);
  localparam logic [CW:0]      LINE_CREDITS = (CW+1)'(WORDS_PER_LINE);
  localparam logic [CW:0]      MAX_CREDITS  = (CW+1)'(OUT_DEPTH);
  localparam logic [LEN_W-1:0] WPL          = LEN_W'(WORDS_PER_LINE);

  t_sched_state     state_q, state_d;
  logic [LEN_W-1:0] len_q, issued_q, rem;
  logic [PW-1:0]    pad_left_q;
  logic [CW-1:0]    credits_q;
  logic [CW:0]      credits_sum;
  logic             have_credit, issue, pad_slot, slot, last_issue;
  logic             dl_valid, dl_pad, dl_any;

  assign have_credit = credits_q != '0;
  assign rem         = len_q % WPL;
  assign issue       = !reset && state_q == S_RUN && !in_empty && have_credit && issued_q < len_q;
  assign pad_slot    = !reset && state_q == S_PAD && have_credit;
  assign slot        = issue | pad_slot;
  assign last_issue  = issue && (issued_q + LEN_W'(1) == len_q);
  assign credits_sum = {1'b0, credits_q} + (out_rd_en ? LINE_CREDITS : '0) - (CW+1)'(slot);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (num_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_issue) state_d = (rem != '0) ? S_PAD : S_DRAIN;
      S_PAD:   if (pad_slot && pad_left_q == PW'(1)) state_d = S_DRAIN;
      S_DRAIN: if (!dl_any) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      pad_left_q   <= '0;
      credits_q    <= CW'(OUT_DEPTH);
      total_lines  <= '0;
      err_zero_len <= 1'b0;
    end else begin
      assert (credits_sum <= MAX_CREDITS);
      state_q   <= state_d;
      credits_q <= credits_sum[CW-1:0];
      if (state_q == S_IDLE && start) begin
        len_q        <= num_words;
        issued_q     <= '0;
        total_lines  <= (num_words / WPL) + LEN_W'((num_words % WPL) != '0);
        err_zero_len <= num_words == '0;
      end
      if (issue) issued_q <= issued_q + LEN_W'(1);
      if (last_issue) pad_left_q <= PW'(WPL - rem);
      else if (pad_slot) pad_left_q <= pad_left_q - PW'(1);
    end
  end

  valid_delay_line #(.PIPE_LAT(PIPE_LAT)) u_delay (
    .clk       (clk),
    .clear     (reset),
    .in_valid  (slot),
    .in_pad    (pad_slot),
    .out_valid (dl_valid),
    .out_pad   (dl_pad),
    .any_valid (dl_any)
  );

  assign in_rd_en  = issue;
  assign out_wr_en = dl_valid && !reset;
  assign out_pad   = dl_valid && dl_pad && !reset;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;

endmodule

// File: tb/tb_mult_pipe_sched.sv
// tb/tb_mult_pipe_sched.sv - self-checking bench for the multiply issue scheduler
module tb_mult_pipe_sched;

  localparam int LAT = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_empty = 1'b0, out_rd_en = 1'b0;
  logic [63:0] num_words = '0;
  logic        in_rd_en, out_wr_en, out_pad, busy, done, err_zero_len;
  logic [63:0] total_lines;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, buf_cnt = 0, pulse_req = 0, kick_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, pad_cnt = 0, done_cnt = 0;
  int first_rd = 0, last_rd = 0, last_wr = 0, done_cyc = 0;
  bit auto_drain = 1'b1;
  int exp_q[$];

  typedef struct {
    logic [63:0] nw;
    bit          tog;
    int          lines;
    int          pads;
  } vec_t;
  vec_t vecs[6];

  mult_pipe_sched #(.PIPE_LAT(4), .OUT_DEPTH(16), .WORDS_PER_LINE(8), .LEN_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_words    (num_words),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .out_wr_en    (out_wr_en),
    .out_pad      (out_pad),
    .out_rd_en    (out_rd_en),
    .total_lines  (total_lines),
    .busy         (busy),
    .done         (done),
    .err_zero_len (err_zero_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Write-side consumer: pops a whole line whenever one is buffered.
  initial forever begin
    @(posedge clk); #1;
    if (!reset && buf_cnt >= 8 && (auto_drain || pulse_req > 0)) begin
      out_rd_en = 1'b1;
      if (!auto_drain) pulse_req--;
    end else begin
      out_rd_en = 1'b0;
    end
  end

  // Scoreboard: each pop predicts a data write LAT cycles later; pads only after all data.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      buf_cnt = 0;
    end else begin
      if (in_rd_en) begin
        check("rd_while_empty", in_empty, 0);
        if (rd_cnt == 0) first_rd = cyc;
        rd_cnt++;
        last_rd = cyc;
        exp_q.push_back(cyc + LAT);
      end
      if (out_wr_en) begin
        wr_cnt++;
        buf_cnt++;
        last_wr = cyc;
        if (out_pad) pad_cnt++;
        if (exp_q.size() == 0) begin
          check("write_is_pad", out_pad, 1);
        end else begin
          check("data_before_pad", out_pad, 0);
          check("wr_latency", cyc, exp_q.pop_front());
        end
      end
      if (out_rd_en) buf_cnt -= 8;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic kick(input logic [63:0] nw);
    rd_cnt = 0; wr_cnt = 0; pad_cnt = 0; done_cnt = 0;
    first_rd = 0; last_rd = 0; last_wr = 0; done_cyc = 0;
    kick_cyc = cyc;
    start = 1'b1;
    num_words = nw;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit tog, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (tog) in_empty = ~in_empty;
      step();
      n++;
    end
    in_empty = 1'b0;
    check("done_count", done_cnt, 1);
    n = 0;
    while (buf_cnt != 0 && n < 50) begin
      step();
      n++;
    end
  endtask

  initial begin
    int w0, n;
    vecs[0] = '{64'd16, 1'b0, 2, 0};
    vecs[1] = '{64'd5,  1'b0, 1, 3};
    vecs[2] = '{64'd8,  1'b1, 1, 0};
    vecs[3] = '{64'd1,  1'b0, 1, 7};
    vecs[4] = '{64'd9,  1'b0, 2, 7};
    vecs[5] = '{64'd24, 1'b0, 3, 0};

    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_in_rd_en", in_rd_en, 0);
    check("reset_out_wr_en", out_wr_en, 0);
    check("reset_out_pad", out_pad, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_zero_len, 0);
    check("reset_lines", total_lines, 0);

    kick(64'd0);
    wait_done(1'b0, 10);
    check("zero_err_set", err_zero_len, 1);
    check("zero_done_latency", (done_cyc - kick_cyc) <= 2, 1);
    check("zero_rd", rd_cnt, 0);
    check("zero_wr", wr_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      kick(vecs[i].nw);
      wait_done(vecs[i].tog, 400);
      check("total_lines", total_lines, vecs[i].lines);
      check("rd_count", rd_cnt, vecs[i].nw);
      check("wr_count", wr_cnt, vecs[i].lines * 8);
      check("pad_count", pad_cnt, vecs[i].pads);
      check("done_after_last_wr", done_cyc, last_wr + 1);
      check("err_zero_len_clear", err_zero_len, 0);
      if (!vecs[i].tog) check("rd_contiguous", last_rd - first_rd, vecs[i].nw - 1);
    end

    auto_drain = 1'b0;
    kick(64'd40);
    repeat (40) step();
    check("stall_rd16", rd_cnt, 16);
    check("stall_busy", busy, 1);
    pulse_req = 1;
    repeat (30) step();
    check("one_line_rd24", rd_cnt, 24);
    auto_drain = 1'b1;
    wait_done(1'b0, 400);
    check("stall_rd_total", rd_cnt, 40);
    check("stall_wr_total", wr_cnt, 40);
    check("stall_pad", pad_cnt, 0);
    check("stall_lines", total_lines, 5);

    kick(64'd16);
    n = 0;
    while (rd_cnt < 6 && n < 50) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_in_rd_en", in_rd_en, 0);
    check("midrst_out_wr_en", out_wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_lines", total_lines, 0);
    w0 = wr_cnt;
    repeat (10) step();
    check("no_wr_after_reset", wr_cnt, w0);
    auto_drain = 1'b0;
    kick(64'd16);
    repeat (30) step();
    check("credits_restored", rd_cnt, 16);
    auto_drain = 1'b1;
    wait_done(1'b0, 400);
    kick(64'd8);
    wait_done(1'b0, 400);
    check("post_rst_rd", rd_cnt, 8);
    check("post_rst_wr", wr_cnt, 8);

    kick(64'd16);
    repeat (3) step();
    start = 1'b1;
    num_words = 64'd3;
    step();
    start = 1'b0;
    wait_done(1'b0, 400);
    check("busy_start_rd", rd_cnt, 16);
    check("busy_start_wr", wr_cnt, 16);
    check("busy_start_lines", total_lines, 2);
    check("busy_start_pad", pad_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
